// File: rtl/hazard_stall_unit.sv
// Pipeline stall/flush controller: load-use, taken-branch and multi-cycle MEM hazards.
// Latency: 0 cycles, outputs are Mealy from state + inputs; backpressure: holds IF..MEM while dmem is not ready.
// Optional perf counters behind HAZARD_PERF_CNT_EN.

package hazard_pkg;
   localparam int REG_ADDR_WIDTH = 5;
   typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_e;
endpackage

module hazard_stall_unit
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int TO_WIDTH    = 8
`ifdef HAZARD_PERF_CNT_EN
   ,
   parameter int CNT_WIDTH   = 32
`endif
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  wb_sel_e                   wb_sel_EX_i,
   input  logic [REG_ADDR_WIDTH-1:0] rd_addr_EX_i,
   input  logic                      RegWrite_EX_i,
   input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_ID_i,
   input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_ID_i,
   input  logic                      rs1_used_ID_i,
   input  logic                      rs2_used_ID_i,
   input  logic                      branch_taken_EX_i,
   input  logic                      dmem_req_MEM_i,
   input  logic                      dmem_ready_i,
   output logic                      stall_IF_o,
   output logic                      stall_ID_o,
   output logic                      stall_EX_o,
   output logic                      stall_MEM_o,
   output logic                      flush_ID_o,
   output logic                      flush_EX_o,
   output logic                      bubble_WB_o,
`ifdef HAZARD_PERF_CNT_EN
   output logic [CNT_WIDTH-1:0]      perf_lu_cnt_o,
   output logic [CNT_WIDTH-1:0]      perf_flush_cnt_o,
   output logic [CNT_WIDTH-1:0]      perf_memwait_cnt_o,
`endif
   output logic                      mem_timeout_o
);

   typedef enum logic {IDLE, MEM_WAIT} state_e;

   state_e              state_q, state_d;
   logic [TO_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
   logic                timeout_d;
   logic                abort, mem_busy, load_use, rs1_hit, rs2_hit;
   logic                act_mem, act_br, act_lu;

   // x0 never carries a hazard, so a load to x0 is ignored.
   assign rs1_hit  = rs1_used_ID_i && (rs1_addr_ID_i == rd_addr_EX_i);
   assign rs2_hit  = rs2_used_ID_i && (rs2_addr_ID_i == rd_addr_EX_i);
   assign load_use = RegWrite_EX_i && (wb_sel_EX_i == WB_MEM) &&
                     (rd_addr_EX_i != '0) && (rs1_hit || rs2_hit);

   assign abort    = (state_q == MEM_WAIT) && !dmem_ready_i &&
                     (wait_cnt_q == TO_WIDTH'(MEM_TIMEOUT));
   assign mem_busy = ((state_q == IDLE) && dmem_req_MEM_i && !dmem_ready_i) ||
                     ((state_q == MEM_WAIT) && !dmem_ready_i && !abort);

   // Gated by rst_n so every enable drops the moment reset is asserted.
   assign act_mem = rst_n && mem_busy;
   assign act_br  = rst_n && !mem_busy && branch_taken_EX_i;
   assign act_lu  = rst_n && !mem_busy && !branch_taken_EX_i && load_use;

   assign stall_IF_o  = act_mem || act_lu;
   assign stall_ID_o  = act_mem || act_lu;
   assign stall_EX_o  = act_mem;
   assign stall_MEM_o = act_mem;
   assign bubble_WB_o = act_mem;
   assign flush_ID_o  = act_br;
   assign flush_EX_o  = act_br || act_lu;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      timeout_d  = mem_timeout_o;
      case (state_q)
         IDLE: begin
            if (dmem_req_MEM_i && !dmem_ready_i) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = TO_WIDTH'(1);
            end
         end
         MEM_WAIT: begin
            if (dmem_ready_i) begin
               state_d    = IDLE;
               wait_cnt_d = '0;
            end else if (abort) begin
               state_d    = IDLE;
               wait_cnt_d = '0;
               timeout_d  = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + TO_WIDTH'(1);
            end
         end
         default: begin
            state_d    = IDLE;
            wait_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         wait_cnt_q    <= '0;
         mem_timeout_o <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_o <= timeout_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_lu_cnt_o      <= '0;
         perf_flush_cnt_o   <= '0;
         perf_memwait_cnt_o <= '0;
      end else begin
         if (act_lu)  perf_lu_cnt_o      <= perf_lu_cnt_o + CNT_WIDTH'(1);
         if (act_br)  perf_flush_cnt_o   <= perf_flush_cnt_o + CNT_WIDTH'(1);
         if (act_mem) perf_memwait_cnt_o <= perf_memwait_cnt_o + CNT_WIDTH'(1);
      end
   end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: stall-count model checked every negedge plus literal checkpoints.
module tb_hazard_stall_unit;
   import hazard_pkg::*;

   localparam int TO = 4;
   localparam logic [6:0] V_NONE = 7'b0000000;
   localparam logic [6:0] V_LU   = 7'b1100010;
   localparam logic [6:0] V_BR   = 7'b0000110;
   localparam logic [6:0] V_MEM  = 7'b1111001;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wb_sel_e    wb_sel;
   logic [4:0] rd, rs1, rs2;
   logic       rw, u1, u2, br, req, rdy;
   logic       s_if, s_id, s_ex, s_mem, f_id, f_ex, b_wb, m_to_o;
   logic [6:0] dut_vec;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] lu_c, fl_c, mw_c;
`endif

   hazard_stall_unit #(.MEM_TIMEOUT(TO), .TO_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .wb_sel_EX_i(wb_sel), .rd_addr_EX_i(rd), .RegWrite_EX_i(rw),
      .rs1_addr_ID_i(rs1), .rs2_addr_ID_i(rs2),
      .rs1_used_ID_i(u1), .rs2_used_ID_i(u2),
      .branch_taken_EX_i(br), .dmem_req_MEM_i(req), .dmem_ready_i(rdy),
      .stall_IF_o(s_if), .stall_ID_o(s_id), .stall_EX_o(s_ex), .stall_MEM_o(s_mem),
      .flush_ID_o(f_id), .flush_EX_o(f_ex), .bubble_WB_o(b_wb),
`ifdef HAZARD_PERF_CNT_EN
      .perf_lu_cnt_o(lu_c), .perf_flush_cnt_o(fl_c), .perf_memwait_cnt_o(mw_c),
`endif
      .mem_timeout_o(m_to_o)
   );

   assign dut_vec = {s_if, s_id, s_ex, s_mem, f_id, f_ex, b_wb};

   int n_cmp = 0;
   int n_fail = 0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, got, exp);
      end
   endtask

   // Model: count how many cycles the current access has already stalled.
   int         m_elapsed;
   bit         m_to;
   int         m_lu_c, m_fl_c, m_mw_c;
   logic       m_lu, m_busy;
   logic [6:0] m_vec;

   always_comb begin
      logic [4:0] hz;
      hz   = (rw && wb_sel == WB_MEM) ? rd : 5'd0;
      m_lu = (hz != 5'd0) && ((u1 && rs1 == hz) || (u2 && rs2 == hz));
      if (m_elapsed == 0) m_busy = req && !rdy;
      else                m_busy = !rdy && (m_elapsed < TO);
      if (!rst_n)       m_vec = V_NONE;
      else if (m_busy)  m_vec = V_MEM;
      else if (br)      m_vec = V_BR;
      else if (m_lu)    m_vec = V_LU;
      else              m_vec = V_NONE;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_elapsed = 0; m_to = 0;
         m_lu_c = 0; m_fl_c = 0; m_mw_c = 0;
      end else begin
         if (m_vec == V_MEM)     m_mw_c++;
         else if (m_vec == V_BR) m_fl_c++;
         else if (m_vec == V_LU) m_lu_c++;
         if (m_busy) m_elapsed++;
         else begin
            if (m_elapsed > 0 && !rdy) m_to = 1;
            m_elapsed = 0;
         end
      end
   end

   always @(negedge clk) begin
      check("outputs", {25'd0, dut_vec}, {25'd0, m_vec});
      check("mem_timeout", {31'd0, m_to_o}, {31'd0, m_to});
`ifdef HAZARD_PERF_CNT_EN
      check("perf_lu", lu_c, m_lu_c);
      check("perf_flush", fl_c, m_fl_c);
      check("perf_memwait", mw_c, m_mw_c);
`endif
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic clear();
      wb_sel = WB_ALU; rd = 0; rs1 = 0; rs2 = 0;
      rw = 0; u1 = 0; u2 = 0; br = 0; req = 0; rdy = 0;
   endtask

   task automatic set_load_use();
      rw = 1; wb_sel = WB_MEM; rd = 5; rs1 = 5; u1 = 1; rs2 = 1; u2 = 1;
   endtask

   task automatic lit(input string nm, input logic [6:0] exp);
      @(negedge clk);
      check(nm, {25'd0, dut_vec}, {25'd0, exp});
      tick();
   endtask

   task automatic run_t1();
      set_load_use();
      lit("t1_lu_stall", V_LU);
      clear();
      lit("t1_after_bubble", V_NONE);
   endtask

   task automatic run_t3();
      clear(); req = 1; rdy = 0;
      for (int i = 0; i < 3; i++) lit("t3_wait", V_MEM);
      rdy = 1;
      lit("t3_ready", V_NONE);
      clear();
      lit("t3_idle", V_NONE);
   endtask

   task automatic run_t4a();
      set_load_use(); br = 1;
      lit("t4_br_over_lu", V_BR);
      clear();
   endtask

   initial begin
      clear();
      set_load_use(); req = 1;
      #2;
      check("reset_outs", {25'd0, dut_vec}, 32'd0);
      check("reset_timeout", {31'd0, m_to_o}, 32'd0);
      tick(); tick();
      rst_n = 1; clear();
      tick();

      run_t1();

      rw = 1; wb_sel = WB_MEM; rd = 0; rs1 = 0; u1 = 1;
      lit("t2_rd_x0", V_NONE);
      rd = 7; rs1 = 3; u1 = 1; rs2 = 7; u2 = 0;
      lit("t2_rs2_unused", V_NONE);
      u2 = 1;
      lit("t2_rs2_used", V_LU);
      clear();

      run_t3();
      req = 1; rdy = 1;
      lit("t3_zero_wait", V_NONE);
      clear();

      run_t4a();
      req = 1; rdy = 0; br = 1;
      lit("t4_br_held_1", V_MEM);
      lit("t4_br_held_2", V_MEM);
      rdy = 1;
      lit("t4_br_on_ready", V_BR);
      br = 0; rdy = 0;
      lit("t4_back_to_back", V_MEM);
      rdy = 1;
      lit("t4_b2b_ready", V_NONE);
      clear();

      req = 1; rdy = 0;
      for (int i = 1; i <= TO; i++) lit("t5_stall", V_MEM);
      @(negedge clk);
      check("t5_abort_release", {25'd0, dut_vec}, {25'd0, V_NONE});
      check("t5_timeout_pre", {31'd0, m_to_o}, 32'd0);
      tick();
      @(negedge clk);
      check("t5_timeout_set", {31'd0, m_to_o}, 32'd1);
      check("t5_rewait", {25'd0, dut_vec}, {25'd0, V_MEM});
      tick();
      @(negedge clk);
      check("t5_timeout_sticky", {31'd0, m_to_o}, 32'd1);
      tick();
      rst_n = 0;
      #1;
      check("t5_async_rst_outs", {25'd0, dut_vec}, 32'd0);
      check("t5_async_rst_to", {31'd0, m_to_o}, 32'd0);
      tick();
      rst_n = 1; clear();
      tick();

`ifdef HAZARD_PERF_CNT_EN
      run_t1();
      run_t3();
      run_t4a();
      @(negedge clk);
      check("t6_lu_cnt", lu_c, 32'd1);
      check("t6_memwait_cnt", mw_c, 32'd3);
      check("t6_flush_cnt", fl_c, 32'd1);
      tick();
`endif

      tick(); tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
